// File: rtl/ram_pkg.sv
// Shared types, default sizes and address check for the simple-dual-port RAM family.
package ram_pkg;

   typedef enum logic {
      RAM_CLEAR = 1'b0,
      RAM_IDLE  = 1'b1
   } ram_state_e;

   localparam int unsigned RAM_DATA_W_DEF = 8;
   localparam int unsigned RAM_DEPTH_DEF  = 8;

   function automatic logic ram_addr_ok(input int unsigned addr, input int unsigned depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every word once, writing zero, then releases the ports.
module ram_clear_seq
   import ram_pkg::*;
#(
   parameter int unsigned DEPTH  = RAM_DEPTH_DEF,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   ram_state_e        state_reg, state_next;
   logic [ADDR_W-1:0] clr_ptr_reg, clr_ptr_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= RAM_CLEAR;
         clr_ptr_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_ptr_reg <= clr_ptr_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      clr_ptr_next = clr_ptr_reg;
      case (state_reg)
         RAM_CLEAR: begin
            if (clr_ptr_reg == LAST_ADDR) begin
               state_next   = RAM_IDLE;
               clr_ptr_next = '0;
            end else begin
               clr_ptr_next = clr_ptr_reg + ADDR_W'(1);
            end
         end
         default: state_next = RAM_IDLE;
      endcase
   end

   // The reset cycle itself must leave the array untouched, hence the rst qualifier.
   always_comb begin
      busy     = (state_reg == RAM_CLEAR);
      clr_we   = busy && !rst;
      clr_addr = clr_ptr_reg;
   end

endmodule

// File: rtl/ram_sdp_param.sv
// Parametrised single-clock simple-dual-port RAM with registered read and clear sweep.
// Define RAM_BYPASS_EN for write-first same-address collisions; default is read-first.
module ram_sdp_param
   import ram_pkg::*;
#(
   parameter  int unsigned DATA_W = RAM_DATA_W_DEF,
   parameter  int unsigned DEPTH  = RAM_DEPTH_DEF,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] out,
   output logic              out_valid,
   output logic              busy,
   output logic              err
);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              accept, wr_in_range, rd_in_range;
   logic              wr_go, rd_go, bad_go;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] out_reg;
   logic              out_valid_reg, err_reg;

   ram_clear_seq #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clear_seq (
      .clk      (clk),
      .rst      (rst),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .busy     (busy)
   );

   always_comb begin
      accept      = !busy && !rst;
      wr_in_range = ram_addr_ok(32'(wr_addr), DEPTH);
      rd_in_range = ram_addr_ok(32'(rd_addr), DEPTH);
      wr_go       = accept && wr && wr_in_range;
      rd_go       = accept && rd;
      bad_go      = accept && ((wr && !wr_in_range) || (rd && !rd_in_range));
   end

`ifdef RAM_BYPASS_EN
   always_comb begin
      rd_word = mem[rd_addr];
      if (wr_go && (wr_addr == rd_addr))
         rd_word = wr_data;
   end
`else
   always_comb begin
      rd_word = mem[rd_addr];
   end
`endif

   // Clear sweep and user writes never overlap because busy gates wr_go.
   always_ff @(posedge clk) begin
      if (clr_we)
         mem[clr_addr] <= '0;
      else if (wr_go)
         mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_reg       <= '0;
         out_valid_reg <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         out_valid_reg <= rd_go;
         err_reg       <= bad_go;
         if (rd_go)
            out_reg <= rd_in_range ? rd_word : '0;
      end
   end

   assign out       = out_reg;
   assign out_valid = out_valid_reg;
   assign err       = err_reg;

endmodule
